scope_3ph_capture: RTL and testbench

- Acquisition core upstream of the scope_3ph AXI4-Lite register slave.
- Decimates a 3-phase sample stream and stores it in a circular BRAM buffer.
- Detects a level-crossing trigger and freezes a window of pre- and post-trigger samples.
- The register slave arms it, reads status, and reads samples back via a 1-cycle-latency port.

---
 rtl/scope_3ph_capture.sv | 233 +++++++++++++++++++++++
 tb/tb_scope_3ph_capture.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/scope_3ph_capture.sv
// Three-phase scope acquisition core: decimation, circular capture buffer, level trigger, readback port.
// Optional auto-trigger timeout is enabled with `define SCOPE_3PH_CAPTURE_AUTO_TRIG_EN.
module scope_3ph_capture #(
    parameter int DATA_W      = 16,
    parameter int DEPTH_LOG2  = 10,
    parameter int DECIM_W     = 16,
    parameter int AUTO_TRIG_W = 24
) (
    input  logic                          s00_axi_aclk,
    input  logic                          s00_axi_aresetn,
    input  logic                          sample_valid,
    input  logic signed [DATA_W-1:0]      ch_a,
    input  logic signed [DATA_W-1:0]      ch_b,
    input  logic signed [DATA_W-1:0]      ch_c,
    input  logic                          arm,
    input  logic [1:0]                    trig_src,
    input  logic                          trig_slope,
    input  logic signed [DATA_W-1:0]      trig_level,
    input  logic [DEPTH_LOG2-1:0]         pretrig_len,
    input  logic [DECIM_W-1:0]            decim,
    input  logic [AUTO_TRIG_W-1:0]        auto_timeout,
    input  logic                          rd_en,
    input  logic [DEPTH_LOG2-1:0]         rd_addr,
    input  logic [1:0]                    rd_ch,
    output logic [31:0]                   rd_data,
    output logic                          busy,
    output logic                          done,
    output logic [2:0]                    state,
    output logic [DEPTH_LOG2-1:0]         start_addr,
    output logic [DEPTH_LOG2-1:0]         trig_addr,
    output logic                          triggered_auto
);

    localparam int DEPTH = 2**DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] ONE_A = 1;
    localparam logic [DECIM_W-1:0]    ONE_D = 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_WAIT = 3'd2,
        S_POST = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                    st;
    logic [DECIM_W-1:0]        decim_l;
    logic [DECIM_W-1:0]        dcnt;
    logic [DEPTH_LOG2-1:0]     pretrig_l;
    logic [1:0]                trig_src_l;
    logic                      trig_slope_l;
    logic signed [DATA_W-1:0]  trig_level_l;
    logic [DEPTH_LOG2-1:0]     wr_ptr;
    logic [DEPTH_LOG2-1:0]     pre_cnt;
    logic [DEPTH_LOG2-1:0]     post_cnt;
    logic signed [DATA_W-1:0]  prev_val;
    logic                      have_prev;

    logic                      accept;
    logic                      wr_en;
    logic signed [DATA_W-1:0]  cur_val;
    logic                      level_hit;
    logic                      auto_hit;

    function automatic logic [31:0] sext(input logic signed [DATA_W-1:0] v);
        logic signed [31:0] w;
        w = 32'(v);
        return w;
    endfunction

    assign accept = sample_valid && (dcnt == decim_l);
    assign wr_en  = accept && !arm &&
                    (st == S_PRE || st == S_WAIT || (st == S_POST && post_cnt != '0));
    assign state  = st;

    always_comb begin
        cur_val = ch_c;
        case (trig_src_l)
            2'd0:    cur_val = ch_a;
            2'd1:    cur_val = ch_b;
            default: cur_val = ch_c;
        endcase
    end

    always_comb begin
        level_hit = 1'b0;
        if (trig_src_l == 2'd3)
            level_hit = 1'b1;
        else if (have_prev) begin
            if (trig_slope_l)
                level_hit = (prev_val > trig_level_l) && (cur_val <= trig_level_l);
            else
                level_hit = (prev_val < trig_level_l) && (cur_val >= trig_level_l);
        end
    end

`ifdef SCOPE_3PH_CAPTURE_AUTO_TRIG_EN
    localparam logic [AUTO_TRIG_W-1:0] ONE_T = 1;
    logic [AUTO_TRIG_W-1:0] auto_cnt;
    assign auto_hit = (auto_timeout != '0) && ((auto_cnt + ONE_T) == auto_timeout);
`else
    logic unused_auto;
    assign auto_hit    = 1'b0;
    assign unused_auto = ^auto_timeout;
`endif

    // Decimation counter: runs on every valid sample, restarts on arm
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn)
            dcnt <= '0;
        else if (arm)
            dcnt <= '0;
        else if (sample_valid)
            dcnt <= accept ? '0 : dcnt + ONE_D;
    end

    // Capture FSM
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            st             <= S_IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            triggered_auto <= 1'b0;
            decim_l        <= '0;
            pretrig_l      <= '0;
            trig_src_l     <= '0;
            trig_slope_l   <= 1'b0;
            trig_level_l   <= '0;
            wr_ptr         <= '0;
            pre_cnt        <= '0;
            post_cnt       <= '0;
            prev_val       <= '0;
            have_prev      <= 1'b0;
            start_addr     <= '0;
            trig_addr      <= '0;
`ifdef SCOPE_3PH_CAPTURE_AUTO_TRIG_EN
            auto_cnt       <= '0;
`endif
        end else if (arm) begin
            decim_l        <= decim;
            pretrig_l      <= pretrig_len;
            trig_src_l     <= trig_src;
            trig_slope_l   <= trig_slope;
            trig_level_l   <= trig_level;
            wr_ptr         <= '0;
            pre_cnt        <= '0;
            have_prev      <= 1'b0;
            done           <= 1'b0;
            busy           <= 1'b1;
            triggered_auto <= 1'b0;
            st             <= (pretrig_len == '0) ? S_WAIT : S_PRE;
`ifdef SCOPE_3PH_CAPTURE_AUTO_TRIG_EN
            auto_cnt       <= '0;
`endif
        end else begin
            case (st)
                S_PRE: if (accept) begin
                    wr_ptr  <= wr_ptr + ONE_A;
                    pre_cnt <= pre_cnt + ONE_A;
                    if ((pre_cnt + ONE_A) == pretrig_l) begin
                        st        <= S_WAIT;
                        have_prev <= 1'b0;
`ifdef SCOPE_3PH_CAPTURE_AUTO_TRIG_EN
                        auto_cnt  <= '0;
`endif
                    end
                end
                S_WAIT: if (accept) begin
                    wr_ptr    <= wr_ptr + ONE_A;
                    prev_val  <= cur_val;
                    have_prev <= 1'b1;
`ifdef SCOPE_3PH_CAPTURE_AUTO_TRIG_EN
                    auto_cnt  <= auto_cnt + ONE_T;
`endif
                    if (level_hit || auto_hit) begin
                        trig_addr      <= wr_ptr;
                        start_addr     <= wr_ptr - pretrig_l;
                        // DEPTH-1-pretrig_l is the bitwise complement within the address width
                        post_cnt       <= ~pretrig_l;
                        triggered_auto <= auto_hit && !level_hit;
                        st             <= S_POST;
                    end
                end
                S_POST: begin
                    if (post_cnt == '0) begin
                        st   <= S_DONE;
                        done <= 1'b1;
                        busy <= 1'b0;
                    end else if (accept) begin
                        wr_ptr   <= wr_ptr + ONE_A;
                        post_cnt <= post_cnt - ONE_A;
                    end
                end
                default: ;
            endcase
        end
    end

    // Buffer: simple dual-port RAM, read-first on address collision
    logic [3*DATA_W-1:0]   mem [DEPTH];
    logic [3*DATA_W-1:0]   rd_word_p0;
    logic [DEPTH_LOG2-1:0] rd_phys;

    assign rd_phys = start_addr + rd_addr;

    always_ff @(posedge s00_axi_aclk) begin
        if (wr_en)
            mem[wr_ptr] <= {ch_c, ch_b, ch_a};
        if (rd_en)
            rd_word_p0 <= mem[rd_phys];
    end

    // Channel select resets to 3 so rd_data is 0 out of reset without resetting the RAM output
    logic [1:0] rd_sel_p0;

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn)
            rd_sel_p0 <= 2'd3;
        else if (rd_en)
            rd_sel_p0 <= rd_ch;
    end

    always_comb begin
        rd_data = '0;
        case (rd_sel_p0)
            2'd0:    rd_data = sext(rd_word_p0[DATA_W-1:0]);
            2'd1:    rd_data = sext(rd_word_p0[2*DATA_W-1:DATA_W]);
            2'd2:    rd_data = sext(rd_word_p0[3*DATA_W-1:2*DATA_W]);
            default: rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_scope_3ph_capture.sv
// Directed bench for scope_3ph_capture with a 16-deep buffer; readback checked from a vector table.
module tb_scope_3ph_capture;

    localparam int DW = 16;
    localparam int AL = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 sample_valid;
    logic signed [DW-1:0] ch_a, ch_b, ch_c;
    logic                 arm;
    logic [1:0]           trig_src;
    logic                 trig_slope;
    logic signed [DW-1:0] trig_level;
    logic [AL-1:0]        pretrig_len;
    logic [15:0]          decim;
    logic [23:0]          auto_timeout;
    logic                 rd_en;
    logic [AL-1:0]        rd_addr;
    logic [1:0]           rd_ch;
    logic [31:0]          rd_data;
    logic                 busy, done, triggered_auto;
    logic [2:0]           state;
    logic [AL-1:0]        start_addr, trig_addr;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    scope_3ph_capture #(.DATA_W(DW), .DEPTH_LOG2(AL), .DECIM_W(16), .AUTO_TRIG_W(24)) dut (
        .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n), .sample_valid(sample_valid),
        .ch_a(ch_a), .ch_b(ch_b), .ch_c(ch_c), .arm(arm), .trig_src(trig_src),
        .trig_slope(trig_slope), .trig_level(trig_level), .pretrig_len(pretrig_len),
        .decim(decim), .auto_timeout(auto_timeout), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_ch(rd_ch), .rd_data(rd_data), .busy(busy), .done(done), .state(state),
        .start_addr(start_addr), .trig_addr(trig_addr), .triggered_auto(triggered_auto)
    );

    typedef struct {
        int          scen;
        logic [1:0]  ch;
        logic [3:0]  idx;
        logic [31:0] exp;
    } rd_vec_t;

    rd_vec_t rt[$];

    // One period of a coarse sine used for the falling-slope capture
    int sine_tbl[12] = '{0, 40, 70, 80, 70, 40, 0, -40, -60, -80, -60, -40};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic do_arm(input logic [1:0] src, input logic slope, input int level,
                          input int pre, input int dec, input int ato);
        trig_src     = src;
        trig_slope   = slope;
        trig_level   = DW'(level);
        pretrig_len  = AL'(pre);
        decim        = 16'(dec);
        auto_timeout = 24'(ato);
        sample_valid = 1'b0;
        arm          = 1'b1;
        tick();
        arm          = 1'b0;
    endtask

    task automatic set_ramp(input int a);
        ch_a = DW'(a);
        ch_b = DW'(-a);
        ch_c = DW'(a + 5);
    endtask

    task automatic run_reads(input int scen);
        foreach (rt[k]) begin
            if (rt[k].scen == scen) begin
                rd_en   = 1'b1;
                rd_addr = rt[k].idx;
                rd_ch   = rt[k].ch;
                tick();
                rd_en   = 1'b0;
                check($sformatf("s%0d rd ch%0d idx%0d", scen, rt[k].ch, rt[k].idx), rd_data, rt[k].exp);
            end
        end
    endtask

    initial begin
        int n;

        rt.push_back('{1, 2'd0, 4'd0,  32'd60});
        rt.push_back('{1, 2'd0, 4'd4,  32'd100});
        rt.push_back('{1, 2'd0, 4'd15, 32'd210});
        rt.push_back('{1, 2'd1, 4'd4,  32'hFFFF_FF9C});
        rt.push_back('{1, 2'd2, 4'd4,  32'd105});
        rt.push_back('{1, 2'd3, 4'd4,  32'd0});
        rt.push_back('{2, 2'd0, 4'd0,  32'd40});
        rt.push_back('{2, 2'd0, 4'd4,  32'd100});
        rt.push_back('{2, 2'd0, 4'd5,  32'd115});
        rt.push_back('{2, 2'd0, 4'd15, 32'd265});
        rt.push_back('{3, 2'd0, 4'd0,  32'd7});
        rt.push_back('{3, 2'd0, 4'd1,  32'd10});
        rt.push_back('{3, 2'd0, 4'd15, 32'd52});
        rt.push_back('{4, 2'd2, 4'd2,  32'hFFFF_FFC4});
        rt.push_back('{4, 2'd2, 4'd0,  32'd0});
        rt.push_back('{4, 2'd2, 4'd1,  32'hFFFF_FFD8});
        rt.push_back('{4, 2'd2, 4'd15, 32'hFFFF_FFB0});
        rt.push_back('{4, 2'd0, 4'd2,  32'd8});
        rt.push_back('{5, 2'd0, 4'd0,  32'd60});
        rt.push_back('{5, 2'd0, 4'd4,  32'd100});
        rt.push_back('{5, 2'd0, 4'd15, 32'd210});

        rst_n = 1'b0; sample_valid = 1'b0; arm = 1'b0; rd_en = 1'b0;
        rd_addr = '0; rd_ch = '0; set_ramp(0);
        trig_src = '0; trig_slope = 1'b0; trig_level = '0; pretrig_len = '0;
        decim = '0; auto_timeout = '0;
        tick(); tick();
        check("rst state", 32'(state), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst rd_data", rd_data, 32'd0);
        check("rst start_addr", 32'(start_addr), 32'd0);
        check("rst trig_addr", 32'(trig_addr), 32'd0);
        check("rst triggered_auto", 32'(triggered_auto), 32'd0);
        rst_n = 1'b1;
        tick();

        // Scenario 1: rising edge on ch_a ramp, pretrig 4
        do_arm(2'd0, 1'b0, 100, 4, 0, 0);
        check("s1 arm state", 32'(state), 32'd1);
        check("s1 arm busy", 32'(busy), 32'd1);
        n = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            sample_valid = 1'b1; set_ramp(i * 10);
            tick(); n++;
            if (i == 9)  check("s1 pre-trig state", 32'(state), 32'd2);
            if (i == 10) check("s1 trig state", 32'(state), 32'd3);
        end
        sample_valid = 1'b0;
        check("s1 fed", 32'(n), 32'd23);
        check("s1 done", 32'(done), 32'd1);
        check("s1 busy", 32'(busy), 32'd0);
        check("s1 state", 32'(state), 32'd4);
        check("s1 trig_addr", 32'(trig_addr), 32'd10);
        check("s1 start_addr", 32'(start_addr), 32'd6);
        run_reads(1);
        rd_en = 1'b1; rd_addr = 4'd0; rd_ch = 2'd0; tick(); rd_en = 1'b0;
        rd_addr = 4'd9; rd_ch = 2'd1; tick(); tick();
        check("s1 rd hold", rd_data, 32'd60);

        // Scenario 2: decimate by 3, ramp step 5
        do_arm(2'd0, 1'b0, 100, 4, 2, 0);
        n = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            sample_valid = 1'b1; set_ramp(i * 5);
            tick(); n++;
        end
        sample_valid = 1'b0;
        check("s2 fed", 32'(n), 32'd55);
        check("s2 trig_addr", 32'(trig_addr), 32'd6);
        check("s2 start_addr", 32'(start_addr), 32'd2);
        run_reads(2);

        // Scenario 3: forced trigger, no pre-trigger samples
        do_arm(2'd3, 1'b0, 0, 0, 0, 0);
        check("s3 arm state", 32'(state), 32'd2);
        for (int i = 0; i < 16; i++) begin
            sample_valid = 1'b1; set_ramp(3 * i + 7);
            tick();
            if (i == 0) check("s3 trig state", 32'(state), 32'd3);
        end
        check("s3 done after 16", 32'(done), 32'd0);
        set_ramp(999);
        tick();
        sample_valid = 1'b0;
        check("s3 done", 32'(done), 32'd1);
        check("s3 trig_addr", 32'(trig_addr), 32'd0);
        check("s3 start_addr", 32'(start_addr), 32'd0);
        run_reads(3);

        // Scenario 4: falling edge on ch_c sine
        do_arm(2'd2, 1'b1, -50, 2, 0, 0);
        for (int i = 0; i < 60 && !done; i++) begin
            sample_valid = 1'b1;
            ch_a = DW'(i); ch_b = '0; ch_c = DW'(sine_tbl[i % 12]);
            tick();
        end
        sample_valid = 1'b0;
        check("s4 done", 32'(done), 32'd1);
        check("s4 trig_addr", 32'(trig_addr), 32'd8);
        check("s4 start_addr", 32'(start_addr), 32'd6);
        run_reads(4);

        // Scenario 5: re-arm in POST with a coincident sample that must be dropped
        do_arm(2'd0, 1'b0, 100, 4, 0, 0);
        for (int i = 0; i < 14; i++) begin
            sample_valid = 1'b1; set_ramp(i * 10);
            tick();
        end
        check("s5 in post", 32'(state), 32'd3);
        arm = 1'b1; sample_valid = 1'b1; set_ramp(999);
        tick();
        arm = 1'b0;
        check("s5 rearm state", 32'(state), 32'd1);
        check("s5 rearm done", 32'(done), 32'd0);
        for (int i = 0; i < 60 && !done; i++) begin
            sample_valid = 1'b1; set_ramp(i * 10);
            tick();
            if (i == 10) check("s5 mid done", 32'(done), 32'd0);
        end
        sample_valid = 1'b0;
        check("s5 done", 32'(done), 32'd1);
        check("s5 trig_addr", 32'(trig_addr), 32'd10);
        check("s5 start_addr", 32'(start_addr), 32'd6);
        run_reads(5);

        // Scenario 6: constant input never crosses; auto-trigger only when built in
        do_arm(2'd0, 1'b0, 100, 4, 0, 8);
        for (int i = 0; i < 40 && !done; i++) begin
            sample_valid = 1'b1; set_ramp(0); ch_c = '0;
            tick();
        end
        sample_valid = 1'b0;
`ifdef SCOPE_3PH_CAPTURE_AUTO_TRIG_EN
        check("s6 auto done", 32'(done), 32'd1);
        check("s6 auto trig_addr", 32'(trig_addr), 32'd11);
        check("s6 auto start_addr", 32'(start_addr), 32'd7);
        check("s6 triggered_auto", 32'(triggered_auto), 32'd1);
        do_arm(2'd0, 1'b0, 100, 4, 0, 0);
        check("s6 rearm triggered_auto", 32'(triggered_auto), 32'd0);
        for (int i = 0; i < 40; i++) begin
            sample_valid = 1'b1; set_ramp(0); ch_c = '0;
            tick();
        end
        sample_valid = 1'b0;
`endif
        check("s6 busy", 32'(busy), 32'd1);
        check("s6 state", 32'(state), 32'd2);
        check("s6 triggered_auto idle", 32'(triggered_auto), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

endmodule
